// File: rtl/uart_tx_parity_odd.sv
// -----------------------------------------------------------------------------
// uart_tx_parity_odd
//
// Nibble-wide serial transmitter with an odd-parity bit, an optional forced
// idle gap after every frame and a break generator.
//
// Frame on 'signal', one bit per clock:
//   start(0), D0, D1, D2, D3, parity, stop(1)
// The parity bit makes D0..D3 plus parity carry an odd number of ones.
//
// Parameters
//   IDLE_GAP   forced idle-high cycles after each stop bit or break (0..15)
//   BREAK_LEN  cycles the line is held low for a break (11..255)
//
// Ports
//   clk         clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   data_in     payload nibble, captured when data_valid && data_ready
//   data_valid  producer offers data_in
//   data_ready  a nibble can be accepted this cycle
//   send_break  request a line break (looked at only while idle)
//   signal      registered serial line
//   busy        high whenever the transmitter is not idle
//   frame_done  high during the stop-bit cycle of a data frame
// -----------------------------------------------------------------------------
module uart_tx_parity_odd #(
    parameter int unsigned IDLE_GAP  = 1,
    parameter int unsigned BREAK_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       send_break,
    output logic       signal,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP,
        S_BREAK
    } state_t;

    // Without a forced gap the next nibble may be taken during the stop bit.
    localparam bit       BACK_TO_BACK    = (IDLE_GAP == 0);
    localparam logic [7:0] GAP_LOAD       = 8'(IDLE_GAP);
    // A break is always followed by at least one idle-high cycle so the
    // receiver can see the end of the break before a new start bit.
    localparam logic [7:0] BREAK_GAP_LOAD = (IDLE_GAP == 0) ? 8'd1 : 8'(IDLE_GAP);
    // Out of reset the line idles high one cycle longer than the normal gap,
    // guaranteeing a full idle cycle before the first start bit.
    localparam logic [7:0] RESET_GAP_LOAD = 8'(IDLE_GAP + 1);
    localparam logic [7:0] BREAK_LOAD     = 8'(BREAK_LEN);

    state_t     state_q,   state_d;
    logic [1:0] bit_idx_q, bit_idx_d;
    logic [3:0] shift_q,   shift_d;
    logic       parity_q,  parity_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] brk_cnt_q, brk_cnt_d;
    logic       signal_q,  signal_d;
    logic       accept;

    // A pending break in IDLE takes priority, so ready is withdrawn at once.
    assign data_ready = ((state_q == S_IDLE) && !send_break) ||
                        (BACK_TO_BACK && (state_q == S_STOP));
    assign accept     = data_valid && data_ready;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP);
    assign signal     = signal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_GAP;
            bit_idx_q <= 2'd0;
            shift_q   <= 4'd0;
            parity_q  <= 1'b0;
            gap_cnt_q <= RESET_GAP_LOAD;
            brk_cnt_q <= 8'd0;
            signal_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            gap_cnt_q <= gap_cnt_d;
            brk_cnt_q <= brk_cnt_d;
            signal_q  <= signal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        gap_cnt_d = gap_cnt_q;
        brk_cnt_d = brk_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (send_break) begin
                    state_d   = S_BREAK;
                    brk_cnt_d = BREAK_LOAD;
                end else if (accept) begin
                    state_d  = S_START;
                    shift_d  = data_in;
                    parity_d = ~^data_in;
                end
            end
            S_START: begin
                state_d   = S_DATA;
                bit_idx_d = 2'd0;
            end
            S_DATA: begin
                if (bit_idx_q == 2'd3) begin
                    state_d = S_PARITY;
                end else begin
                    bit_idx_d = bit_idx_q + 2'd1;
                    // Shift so the bit on the line is always shift[0].
                    shift_d   = {1'b0, shift_q[3:1]};
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                if (accept) begin
                    state_d  = S_START;
                    shift_d  = data_in;
                    parity_d = ~^data_in;
                end else if (!BACK_TO_BACK) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gap_cnt_d = (gap_cnt_q == 8'd0) ? 8'd0 : gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                brk_cnt_d = (brk_cnt_q == 8'd0) ? 8'd0 : brk_cnt_q - 8'd1;
                if (brk_cnt_q <= 8'd1) begin
                    state_d   = S_GAP;
                    gap_cnt_d = BREAK_GAP_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is registered and follows the state being entered, so it
    // always matches the state register in the same cycle.
    always_comb begin
        signal_d = 1'b1;
        case (state_d)
            S_START:  signal_d = 1'b0;
            S_BREAK:  signal_d = 1'b0;
            S_DATA:   signal_d = shift_d[0];
            S_PARITY: signal_d = parity_d;
            default:  signal_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_parity_odd.sv
// -----------------------------------------------------------------------------
// Bench for uart_tx_parity_odd. Two instances share the stimulus:
//   u_a : IDLE_GAP=1, BREAK_LEN=16
//   u_b : IDLE_GAP=0, BREAK_LEN=16 (back-to-back frames)
// A queue-based line model predicts, per instance, the future line cells
// (signal level plus frame_done). The compare process checks every cycle and
// also checks hand-written literal expectations posted by the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_tx_parity_odd;

    localparam int GAP_A = 1;
    localparam int GAP_B = 0;
    localparam int BLEN  = 16;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic       data_valid;
    logic       send_break;
    logic       rdy_a, sig_a, busy_a, fd_a;
    logic       rdy_b, sig_b, busy_b, fd_b;

    uart_tx_parity_odd #(.IDLE_GAP(GAP_A), .BREAK_LEN(BLEN)) u_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_a), .send_break(send_break), .signal(sig_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    uart_tx_parity_odd #(.IDLE_GAP(GAP_B), .BREAK_LEN(BLEN)) u_b (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_b), .send_break(send_break), .signal(sig_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cell: [1] = frame_done, [0] = line level. Empty queue = idle line.
    typedef logic [1:0] cellq_t [$];
    cellq_t qa, qb;

    int         n_cmp;
    int         n_bad;
    logic       lit_en;
    logic       lit_sel;
    logic [3:0] lit_exp;   // {ready, busy, frame_done, signal}
    string      lit_name;
    logic       tmo;

    task automatic load_reset(input int gap, output cellq_t q);
        q = {};
        repeat (gap + 1) q.push_back(2'b01);
    endtask

    // Expected {ready, busy, frame_done, signal} for the current cycle.
    function automatic logic [3:0] m_out(input cellq_t q, input int gap);
        if (q.size() == 0) return {!send_break, 1'b0, 1'b0, 1'b1};
        return {(gap == 0) && q[0][1], 1'b1, q[0][1], q[0][0]};
    endfunction

    task automatic m_step(input cellq_t qi, input int gap, output cellq_t qo);
        logic [3:0] o;
        int         ones;
        logic       par;
        o  = m_out(qi, gap);
        qo = qi;
        if (o[3] && data_valid) begin
            if (qo.size() != 0) void'(qo.pop_front());
            ones = $countones(data_in);
            par  = ((ones % 2) == 0);
            qo.push_back(2'b00);
            for (int i = 0; i < 4; i++) qo.push_back({1'b0, data_in[i]});
            qo.push_back({1'b0, par});
            qo.push_back(2'b11);
            repeat (gap) qo.push_back(2'b01);
        end else if (qo.size() == 0 && send_break) begin
            repeat (BLEN) qo.push_back(2'b00);
            repeat ((gap == 0) ? 1 : gap) qo.push_back(2'b01);
        end else if (qo.size() != 0) begin
            void'(qo.pop_front());
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: checks on the falling edge, then advances the model
    // with the inputs that will be sampled on the next rising edge.
    initial begin
        logic [3:0] ea, eb;
        cellq_t     t;
        bit         tmo_seen;
        tmo_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                load_reset(GAP_A, qa);
                load_reset(GAP_B, qb);
            end
            ea = m_out(qa, GAP_A);
            eb = m_out(qb, GAP_B);
            chk("A.ready",  {3'b0, rdy_a},  {3'b0, ea[3]});
            chk("A.busy",   {3'b0, busy_a}, {3'b0, ea[2]});
            chk("A.fdone",  {3'b0, fd_a},   {3'b0, ea[1]});
            chk("A.signal", {3'b0, sig_a},  {3'b0, ea[0]});
            chk("B.ready",  {3'b0, rdy_b},  {3'b0, eb[3]});
            chk("B.busy",   {3'b0, busy_b}, {3'b0, eb[2]});
            chk("B.fdone",  {3'b0, fd_b},   {3'b0, eb[1]});
            chk("B.signal", {3'b0, sig_b},  {3'b0, eb[0]});
            if (lit_en) begin
                if (lit_sel)
                    chk({"lit ", lit_name, " B{rdy,busy,fd,sig}"}, {rdy_b, busy_b, fd_b, sig_b}, lit_exp);
                else
                    chk({"lit ", lit_name, " A{rdy,busy,fd,sig}"}, {rdy_a, busy_a, fd_a, sig_a}, lit_exp);
            end
            if (tmo && !tmo_seen) begin
                tmo_seen = 1;
                chk("wait_idle timeout", 4'd1, 4'd0);
            end
            if (!reset) begin
                m_step(qa, GAP_A, t); qa = t;
                m_step(qb, GAP_B, t); qb = t;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Post a literal expectation for the current cycle, then advance one cycle.
    task automatic lit(input bit sel, input string nm, input logic [3:0] e);
        lit_sel  = sel;
        lit_name = nm;
        lit_exp  = e;
        lit_en   = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (qa.size() == 0 && qb.size() == 0) return;
            tick();
        end
        tmo = 1'b1;
    endtask

    // One frame on instance A with a literal bit sequence (seq[6] first).
    // send_break is pulsed during cycle brk_at of the frame (-1: never).
    task automatic frame_lit(input logic [3:0] nib, input logic [6:0] seq,
                             input string nm, input int brk_at);
        wait_idle();
        data_in    = nib;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_break = (i == brk_at);
            lit(1'b0, nm, {1'b0, 1'b1, (i == 6), seq[6 - i]});
        end
        send_break = 1'b0;
        lit(1'b0, {nm, "_gap"},  4'b0101);
        lit(1'b0, {nm, "_idle"}, 4'b1001);
    endtask

    initial begin
        logic [6:0] s1;
        logic [6:0] s2;
        n_cmp      = 0;
        n_bad      = 0;
        lit_en     = 1'b0;
        lit_sel    = 1'b0;
        lit_exp    = 4'd0;
        lit_name   = "";
        tmo        = 1'b0;
        reset      = 1'b1;
        data_in    = 4'd0;
        data_valid = 1'b0;
        send_break = 1'b0;

        // Reset values, then the post-reset idle gap on A.
        tick();
        lit(1'b0, "rst_hold", 4'b0101);
        reset = 1'b0;
        lit(1'b0, "rst_gap1", 4'b0101);
        lit(1'b0, "rst_gap2", 4'b0101);
        lit(1'b0, "rst_idle", 4'b1001);

        // Even number of ones -> parity 1; odd -> parity 0.
        frame_lit(4'b0011, 7'b0110011, "f0011", -1);
        // A break request in mid-frame must be ignored and not queued.
        frame_lit(4'b0111, 7'b0111001, "f0111", 3);

        // Back-to-back frames on B with data_valid held high.
        wait_idle();
        data_in    = 4'b0000;
        data_valid = 1'b1;
        tick();
        data_in = 4'b1111;
        s1 = 7'b0000011;
        for (int i = 0; i < 7; i++)
            lit(1'b1, "b2b_f1", {(i == 6), 1'b1, (i == 6), s1[6 - i]});
        data_valid = 1'b0;
        s2 = 7'b0111111;
        for (int i = 0; i < 7; i++)
            lit(1'b1, "b2b_f2", {(i == 6), 1'b1, (i == 6), s2[6 - i]});
        lit(1'b1, "b2b_idle", 4'b1001);

        // Break wins over simultaneous data; 16 low cycles then one gap.
        wait_idle();
        send_break = 1'b1;
        data_valid = 1'b1;
        data_in    = 4'b0101;
        lit(1'b0, "brk_req", 4'b0001);
        send_break = 1'b0;
        data_valid = 1'b0;
        repeat (BLEN) lit(1'b0, "brk_low", 4'b0100);
        lit(1'b0, "brk_gap",  4'b0101);
        lit(1'b0, "brk_idle", 4'b1001);

        // Reset during D2 aborts the frame and the line goes high at once.
        wait_idle();
        data_in    = 4'b1010;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        lit(1'b0, "abort_start", 4'b0100);
        lit(1'b0, "abort_d0",    4'b0100);
        lit(1'b0, "abort_d1",    4'b0101);
        reset = 1'b1;
        lit(1'b0, "abort_rst",   4'b0101);
        reset = 1'b0;
        lit(1'b0, "abort_gap1",  4'b0101);
        lit(1'b0, "abort_gap2",  4'b0101);
        lit(1'b0, "abort_idle",  4'b1001);
        frame_lit(4'b1010, 7'b0010111, "after_rst", -1);

        // Every nibble once, checked by the model only.
        for (int n = 0; n < 16; n++) begin
            wait_idle();
            data_in    = 4'(n);
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
        end

        wait_idle();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_parity_odd.md
UART_TX_PARITY_ODD -- requirements
Module: uart_tx_parity_odd

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IDLE_GAP  1   number of forced idle-high cycles after each stop bit or break (0..15)
  BREAK_LEN 16  number of cycles the line is held low for a break (11..255)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk         in   1  single clock; all state changes on its rising edge
  reset       in   1  asynchronous, active-high reset
  data_in     in   4  payload nibble, sampled when the handshake completes
  data_valid  in   1  producer offers data_in
  data_ready  out  1  block can accept a nibble this cycle
  send_break  in   1  request a line break
  signal      out  1  serial line to the downstream odd-parity frame checker
  busy        out  1  high in every state except IDLE
  frame_done  out  1  one-cycle pulse during the stop-bit cycle

Function
REQ-003 Frame format SHALL be: start (0), D0, D1, D2, D3 (LSB first), parity, stop (1), with one bit per clk cycle.
REQ-004 The parity bit SHALL be XNOR of data_in[3:0], so that D0..D3 plus parity holds an odd number of ones.
REQ-005 States SHALL be IDLE, START, DATA (2-bit bit index), PARITY, STOP, GAP and BREAK.
REQ-006 signal SHALL be registered, with these values: 1 in IDLE, GAP and STOP; 0 in START and BREAK; the indexed data bit in DATA; the parity bit in PARITY.
REQ-007 The transfer SHALL occur on a rising edge where data_valid && data_ready; data_in SHALL be latched into a shift register on that edge.
REQ-008 After a transfer, the next cycle SHALL be START; the stop bit SHALL appear 6 cycles after START.
REQ-009 data_ready SHALL be high in IDLE.
REQ-010 When IDLE_GAP==0, data_ready SHALL also be high in STOP; a transfer in STOP SHALL go directly to START (back-to-back frames).
REQ-011 data_ready SHALL be low in all other states.
REQ-012 STOP SHALL go to GAP when IDLE_GAP>0 and to IDLE otherwise, unless REQ-010 applies.
REQ-013 GAP SHALL last exactly IDLE_GAP cycles and then go to IDLE.
REQ-014 send_break SHALL be sampled only in IDLE.
REQ-015 When send_break and data_valid are both high in IDLE, send_break SHALL win; data_ready SHALL drop to 0 in that cycle and no data SHALL be accepted.
REQ-016 BREAK SHALL hold signal at 0 for exactly BREAK_LEN cycles, then go to GAP with at least 1 gap cycle, even when IDLE_GAP==0.
REQ-017 send_break asserted while not in IDLE SHALL be ignored; it is not queued.
REQ-018 frame_done SHALL pulse high for exactly the cycle in which signal carries the stop bit; it SHALL NOT pulse for a break.
REQ-019 data_in and data_valid changes while busy SHALL NOT affect the frame in flight.
REQ-020 Gap and break counters SHALL be 8-bit, count down and saturate at 0; no wrap.

Reset
REQ-021 reset SHALL act asynchronously and force the following values.
  signal=1, data_ready=0, busy=1, frame_done=0
  state=GAP with the gap counter loaded to IDLE_GAP+1
REQ-022 The first nibble SHALL therefore be accepted only after at least one full idle-high cycle, so the downstream checker leaves its break state before the first start bit.
REQ-023 reset asserted mid-frame SHALL abort the frame immediately with signal=1; no partial frame resumes after reset.

Verification
REQ-024 Reset release with IDLE_GAP=1 -> signal=1 for 2 cycles; data_ready rises in cycle 3; busy falls with it.
REQ-025 Send data_in=4'b0011 -> signal sequence 0,1,1,0,0,1,1 (start, D0..D3, parity=1, stop); frame_done high only on the final 1; checker raises valid.
REQ-026 Send data_in=4'b0111 -> parity bit 0, sequence 0,1,1,1,0,0,1; checker raises valid, never error.
REQ-027 IDLE_GAP=0, data_valid held high with 4'b0000 then 4'b1111 -> two 7-cycle frames with no idle between; the stop of frame 1 is followed directly by the start of frame 2; parity bits 1 then 1.
REQ-028 send_break and data_valid high together in IDLE, BREAK_LEN=16 -> signal=0 for exactly 16 cycles, then 1; data not accepted; frame_done stays 0; checker returns to idle afterwards.
REQ-029 reset pulsed during the D2 cycle -> signal=1 at once; after release no frame_done for the aborted nibble; the next transfer produces a correct frame.
